// File: rtl/alu_pkg.sv
// Shared definitions for param_alu: opcodes, FSM states, comparison codes, flag bundle.
// The DIV state only exists when PARAM_ALU_DIV_EN is defined.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_MUL  = 4'b0010,
        OP_DIV  = 4'b0011,
        OP_AND  = 4'b0100,
        OP_OR   = 4'b0101,
        OP_NAND = 4'b0110,
        OP_NOR  = 4'b0111,
        OP_XOR  = 4'b1000,
        OP_XNOR = 4'b1001,
        OP_EQ   = 4'b1010,
        OP_GT   = 4'b1011,
        OP_LT   = 4'b1100,
        OP_SHR  = 4'b1101,
        OP_SHL  = 4'b1110,
        OP_NOP  = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef PARAM_ALU_DIV_EN
        ST_DIV  = 2'd1,
`endif
        ST_DONE = 2'd2
    } alu_state_e;

    localparam logic [1:0] CMP_EQ_CODE = 2'd1;
    localparam logic [1:0] CMP_GT_CODE = 2'd2;
    localparam logic [1:0] CMP_LT_CODE = 2'd3;

    typedef struct packed {
        logic arith;
        logic logic_f;
        logic cmp;
        logic shift;
        logic carry;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_divider.sv
// Iterative restoring divider, one quotient bit per cycle over WIDTH cycles.
// Only compiled when PARAM_ALU_DIV_EN is defined.
`ifdef PARAM_ALU_DIV_EN
module alu_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_next;

    // done and quotient reflect the step being applied this cycle, so the
    // final quotient can be captured on the same edge as the last iteration.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = (shifted >= {1'b0, dvs});
        rem_next = fits ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
        quotient = {quo[WIDTH-2:0], fits};
        done     = busy && (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
            rem  <= '0;
            quo  <= '0;
            dvs  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
            rem  <= '0;
            quo  <= dividend;
            dvs  <= divisor;
        end else if (busy) begin
            rem <= rem_next;
            quo <= quotient;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/param_alu.sv
// Parameterised ALU with valid/ready handshake and registered result/flags.
// Define PARAM_ALU_DIV_EN to build in the iterative divider and DIV state.
module param_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_FUN,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] ALU_OUT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Arith_Flag,
    output logic             Logic_Flag,
    output logic             CMP_Flag,
    output logic             Shift_Flag,
    output logic             Carry_Flag,
    output logic             Err_Flag
);

    alu_state_e         state;
    alu_state_e         next_state;
    alu_op_e            op;
    logic               accept;
    logic [WIDTH-1:0]   res_c;
    alu_flags_t         flg_c;
    alu_flags_t         flg_q;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    assign op     = alu_op_e'(ALU_FUN);
    assign accept = in_valid && in_ready;

`ifdef PARAM_ALU_DIV_EN
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;

    assign div_start = accept && (op == OP_DIV) && (B != '0);

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (A),
        .divisor  (B),
        .done     (div_done),
        .quotient (div_quo)
    );
`endif

    always_comb begin
        res_c = '0;
        flg_c = '0;
        sum   = {1'b0, A} + {1'b0, B};
        prod  = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
        case (op)
            OP_ADD:  begin res_c = sum[WIDTH-1:0];  flg_c.arith = 1'b1; flg_c.carry = sum[WIDTH]; end
            OP_SUB:  begin res_c = A - B;           flg_c.arith = 1'b1; flg_c.carry = (A < B); end
            OP_MUL:  begin res_c = prod[WIDTH-1:0]; flg_c.arith = 1'b1; flg_c.carry = |prod[2*WIDTH-1:WIDTH]; end
            OP_DIV:  begin
                flg_c.arith = 1'b1;
                flg_c.err   = 1'b1;
`ifdef PARAM_ALU_DIV_EN
                // Only the divide-by-zero case completes here; B!=0 goes to the divider.
                res_c = '1;
`else
                res_c = '0;
`endif
            end
            OP_AND:  begin res_c = A & B;     flg_c.logic_f = 1'b1; end
            OP_OR:   begin res_c = A | B;     flg_c.logic_f = 1'b1; end
            OP_NAND: begin res_c = ~(A & B);  flg_c.logic_f = 1'b1; end
            OP_NOR:  begin res_c = ~(A | B);  flg_c.logic_f = 1'b1; end
            OP_XOR:  begin res_c = A ^ B;     flg_c.logic_f = 1'b1; end
            OP_XNOR: begin res_c = ~(A ^ B);  flg_c.logic_f = 1'b1; end
            OP_EQ:   begin res_c = (A == B) ? WIDTH'(CMP_EQ_CODE) : '0; flg_c.cmp = 1'b1; end
            OP_GT:   begin res_c = (A > B)  ? WIDTH'(CMP_GT_CODE) : '0; flg_c.cmp = 1'b1; end
            OP_LT:   begin res_c = (A < B)  ? WIDTH'(CMP_LT_CODE) : '0; flg_c.cmp = 1'b1; end
            OP_SHR:  begin res_c = A >> 1;    flg_c.shift = 1'b1; end
            OP_SHL:  begin res_c = A << 1;    flg_c.shift = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
`ifdef PARAM_ALU_DIV_EN
                    next_state = div_start ? ST_DIV : ST_DONE;
`else
                    next_state = ST_DONE;
`endif
                end
            end
`ifdef PARAM_ALU_DIV_EN
            ST_DIV:  if (div_done) next_state = ST_DONE;
`endif
            ST_DONE: if (out_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // rst gates in_ready so nothing is offered while reset is held.
    always_comb begin
        in_ready  = (state == ST_IDLE) && !rst;
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALU_OUT <= '0;
            flg_q   <= '0;
`ifdef PARAM_ALU_DIV_EN
        end else if (accept && !div_start) begin
            ALU_OUT <= res_c;
            flg_q   <= flg_c;
        end else if (div_done) begin
            ALU_OUT <= div_quo;
            flg_q   <= alu_flags_t'{arith: 1'b1, default: 1'b0};
`else
        end else if (accept) begin
            ALU_OUT <= res_c;
            flg_q   <= flg_c;
`endif
        end
    end

    assign Arith_Flag = flg_q.arith;
    assign Logic_Flag = flg_q.logic_f;
    assign CMP_Flag   = flg_q.cmp;
    assign Shift_Flag = flg_q.shift;
    assign Carry_Flag = flg_q.carry;
    assign Err_Flag   = flg_q.err;

endmodule
